// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int MMIO_BASE_DEF = 252;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-input round-robin picker: a lone request wins outright,
// a tie is resolved by prio.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = PORT_CPU;
        case (req)
            2'b01:   gnt_idx = PORT_CPU;
            2'b10:   gnt_idx = PORT_DBG;
            2'b11:   gnt_idx = prio;
            default: gnt_idx = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arb2.sv
// Two-port arbiter/sequencer for the shared 256-byte data memory.
// Optional build macro PROT_MMIO_EN blocks requester-1 writes to MMIO and flags them on err1.
module mem_arb2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err1
);

`ifdef PROT_MMIO_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] MMIO_LO = ADDR_W'(MMIO_BASE);

    state_t              state;
    logic                prio;
    logic                owner;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                prot_q;

    logic                gnt_valid;
    logic                gnt_idx;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                prot_hit;

    rr_arb2 u_pick (
        .req       ({req1, req0}),
        .prio      (prio),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        sel_we    = (gnt_idx == PORT_DBG) ? we1    : we0;
        sel_addr  = (gnt_idx == PORT_DBG) ? addr1  : addr0;
        sel_wdata = (gnt_idx == PORT_DBG) ? wdata1 : wdata0;
        prot_hit  = PROT_EN && (gnt_idx == PORT_DBG) && sel_we && (sel_addr >= MMIO_LO);
    end

    // Memory pins come only from state and capture registers, so they are quiet outside ACCESS.
    assign mem_en    = (state == ACCESS) && !prot_q;
    assign mem_rw    = (state == ACCESS) && rw_q;
    assign mem_addr  = (state == ACCESS) ? addr_q : '0;
    assign mem_wdata = ((state == ACCESS) && rw_q) ? wdata_q : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= PORT_CPU;
            owner   <= PORT_CPU;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            prot_q  <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner   <= gnt_idx;
                        rw_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        prot_q  <= prot_hit;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!rw_q) begin
                        if (owner == PORT_CPU) rdata0 <= mem_rdata;
                        else                   rdata1 <= mem_rdata;
                    end
                    if (owner == PORT_DBG) ack1 <= 1'b1;
                    else                   ack0 <= 1'b1;
                    err1  <= prot_q;
                    prio  <= ~owner;
                    state <= DONE;
                end
                DONE: begin
                    // Requests are deliberately ignored here so a requester can drop req after ack.
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
